spi_mem_arbiter: RTL and testbench
==================================

# spi_mem_arbiter

Sequences and shares the single external SPI RAM link on the uio pins between two on-chip requesters: port 0 (CPU instruction fetch) and port 1 (CPU data load/store). Accepts byte-wide read/write requests on a req/ack handshake, arbitrates round-robin, and runs one complete 23LC-style SPI transaction per request: command, 16-bit address, one data byte. Sits between the CPU core and the top-level pin mapping; its SPI outputs drive CS/MOSI/SCK and it samples MISO.

## Interface
- `CLK_DIV`, default 1: SCK half-period in `clk` cycles; legal values are ≥1.
- `CMD_READ`, default 8'h03: read command byte.
- `CMD_WRITE`, default 8'h02: write command byte.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `m0_req` in 1: port 0 request. Held high until `m0_ack`.
- `m0_we` in 1: port 0 write (1) or read (0).
- `m0_addr` in 16: port 0 byte address.
- `m0_wdata` in 8: port 0 write data.
- `m0_ack` out 1: one-cycle completion pulse.
- `m0_rdata` out 8: port 0 read data, valid from the `m0_ack` cycle.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_ack`, `m1_rdata`: same as port 0, for port 1.
- `busy` out 1: high in any state other than IDLE.
- `gnt` out 1: index of the port owning the current or last transaction.
- `spi_cs_n` out 1: chip select, active low.
- `spi_sck` out 1: serial clock, idle low (mode 0).
- `spi_mosi` out 1: serial data out, MSB first.
- `spi_miso` in 1: serial data in.

## Operation
- States: IDLE → SHIFT → HOLD → GAP → IDLE.
- **IDLE**
  - When any request is high, grant it. If both are high, grant the port not granted last.
  - The last-grant register resets to 1, so port 0 wins the first tie.
  - Latch `we`, `addr` and `wdata` from the granted port into a 32-bit shift register: {cmd, addr[15:8], addr[7:0], wdata}. For a read, the data field is 8'h00.
- **SHIFT**
  - `spi_cs_n`=0. 32 bits, each made of a low phase (D cycles) then a high phase (D cycles), where D=`CLK_DIV`.
  - MOSI shows the current bit for the whole bit period. It changes only while SCK is low, on the first cycle of the low phase.
  - MISO is sampled on the first cycle of each high phase (the cycle SCK rises). Only bits 7..0 (the last 8 samples) are captured, MSB first.
- **HOLD**
  - SCK low, CS still low, D cycles.
- **GAP**
  - Entered with `spi_cs_n`=1. Stays D cycles, then returns to IDLE.
  - The granted port's `ack` pulses for one cycle on GAP entry.
  - On reads, `mX_rdata` updates in the same cycle as the ack.
- **Output holding**
  - `mX_rdata` holds until that port's next read completes.
  - Writes and the other port's transactions never change it.
- **Request behaviour**
  - A request is never aborted. If a port drops `req` mid-transaction, the transaction still completes and `ack` still pulses.
  - Input changes after grant are ignored.
- **`gnt`** updates at grant and holds through GAP and IDLE.
- **Reset values** (asynchronous, any state):
  - State IDLE, `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0.
  - Acks 0, rdata 8'h00, `busy`=0, `gnt`=0.
  - Last-grant register = 1.
  - Reset mid-transaction raises CS immediately. No ack is issued for that transaction.

## Timing
- Request seen high in IDLE at cycle t:
  - t+1: `spi_cs_n` falls, `busy` rises, MOSI = cmd bit 7, SCK low.
- The first SCK rise is at t+1+D, which gives a CS-to-SCK setup of D cycles.
- The last SCK fall is at t+1+64D. HOLD covers t+1+64D … t+64D+D.
- `ack` and `spi_cs_n`↑ occur at t+65D+1, so latency is 65·D+1 cycles (66 cycles at D=1).
- Back in IDLE at t+66D+1, with CS high for ≥D+1 cycles. The next grant is sampled in that cycle.
- A held request with no competitor is therefore serviced back-to-back every 66·D+1 cycles.
- A request asserted in the same cycle as an ack is not granted before IDLE is re-entered.

## Test plan
- **Single read, D=1:** port 0 read at 16'h1234; model returns 8'hA5.
  - MOSI stream is 03 12 34 00.
  - `m0_ack` arrives exactly 66 cycles after req; `m0_rdata`=8'hA5; `m1_rdata` stays 8'h00.
- **Single write, D=2:** port 1 writes 8'h5A to 16'hBEEF.
  - MOSI stream is 02 BE EF 5A, with SCK high/low phases of 2 cycles.
  - `m1_ack` arrives at 131 cycles; `m1_rdata` is unchanged.
- **Contention:** both ports request from reset, held high.
  - Grant order is 0, 1, 0, 1.
  - Each ack is one cycle wide; CS is high ≥2 cycles between frames at D=1.
- **Request withdrawn:** port 0 drops req after 10 cycles.
  - The frame completes and `m0_ack` still pulses at cycle 66.
  - No second transaction starts.
- **Reset mid-frame:** `rst_n` low during bit 20.
  - `spi_cs_n`=1 and `spi_sck`=0 asynchronously; no ack.
  - After release, a port 1 read completes normally and port 0 wins the next tie.
- **MISO sampling:** model drives garbage during cmd/addr and 8'h3C during the data byte.
  - `rdata`=8'h3C; MISO is sampled only on rising SCK.

Source files
------------

// File: rtl/spi_mem_arbiter.sv
// Two-port arbiter in front of a single 23LC-style SPI RAM.
// Each granted request runs one complete frame: command, 16-bit address
// and one data byte, in SPI mode 0, MSB first. Ports are granted
// round-robin, and every frame ends with a one-cycle ack to its owner.
module spi_mem_arbiter #(
  parameter int         CLK_DIV   = 1,
  parameter logic [7:0] CMD_READ  = 8'h03,
  parameter logic [7:0] CMD_WRITE = 8'h02
) (
  input  logic        clk,
  input  logic        rst_n,
  // port 0: instruction fetch
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic        m0_ack,
  output logic [7:0]  m0_rdata,
  // port 1: data load/store
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic        m1_ack,
  output logic [7:0]  m1_rdata,
  // status
  output logic        busy,
  output logic        gnt,
  // SPI pins
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  // The divider counts 0 .. CLK_DIV-1 inside every SCK half-period,
  // inside HOLD and inside GAP.
  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  state_e        state_q, state_d;

  // Frame sequencing
  logic [DW-1:0] div_q;      // cycle within the current half-period
  logic          phase_q;    // 0 = SCK low half, 1 = SCK high half
  logic [4:0]    bit_q;      // frame bit index, 0 = first bit sent
  logic [31:0]   shreg_q;    // {cmd, addr_hi, addr_lo, wdata}, MSB on the wire
  logic [7:0]    rx_q;       // MISO capture during the data byte

  // Transaction ownership
  logic          we_q;
  logic          gnt_q;      // owner of the current or last frame
  logic          last_q;     // round-robin memory; resets to 1 so port 0 wins the first tie

  // Port outputs
  logic          ack0_q, ack1_q;
  logic [7:0]    rdata0_q, rdata1_q;

  // Combinational helpers
  logic          div_done;
  logic          bit_done;
  logic          frame_done;
  logic          hold_done;
  logic          gap_done;
  logic          sample_en;
  logic          any_req;
  logic          sel;
  logic          sel_we;
  logic [15:0]   sel_addr;
  logic [7:0]    sel_wdata;
  logic [31:0]   frame_d;
  logic          ack0_d, ack1_d;

  assign div_done   = (div_q == DIV_LAST);
  assign bit_done   = phase_q && div_done;               // end of a high half
  assign frame_done = bit_done && (bit_q == 5'd31);
  assign hold_done  = (state_q == ST_HOLD) && div_done;
  assign gap_done   = (state_q == ST_GAP) && div_done;

  // MISO is taken in the cycle SCK rises, and only for the data byte (bits 24..31).
  assign sample_en  = (state_q == ST_SHIFT) && phase_q && (div_q == '0) &&
                      (bit_q[4:3] == 2'b11);

  // Round-robin choice between the two requesters and the frame it would load
  always_comb begin
    any_req = m0_req | m1_req;
    if (m0_req && m1_req) begin
      sel = ~last_q;
    end else begin
      sel = m1_req;
    end
    sel_we    = sel ? m1_we    : m0_we;
    sel_addr  = sel ? m1_addr  : m0_addr;
    sel_wdata = sel ? m1_wdata : m0_wdata;
    frame_d   = {(sel_we ? CMD_WRITE : CMD_READ), sel_addr,
                 (sel_we ? sel_wdata : 8'h00)};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> SHIFT -> HOLD -> GAP -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req)    state_d = ST_SHIFT;
      ST_SHIFT: if (frame_done) state_d = ST_HOLD;
      ST_HOLD:  if (div_done)   state_d = ST_GAP;
      ST_GAP:   if (div_done)   state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Output decode: pins come straight from registered state, so CS rises the
  // instant reset is asserted. The ack/rdata next values are formed here.
  always_comb begin
    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    busy     = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        spi_cs_n = 1'b0;
        spi_sck  = phase_q;
        spi_mosi = shreg_q[31];
        busy     = 1'b1;
      end
      ST_HOLD: begin
        spi_cs_n = 1'b0;
        busy     = 1'b1;
        ack0_d   = hold_done && !gnt_q;
        ack1_d   = hold_done &&  gnt_q;
      end
      ST_GAP: begin
        busy     = 1'b1;
      end
      default: ;
    endcase
  end

  // Grant capture, bit/phase sequencing, shifting and MISO capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= 5'd0;
      shreg_q <= 32'h0;
      rx_q    <= 8'h00;
      we_q    <= 1'b0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          div_q   <= '0;
          phase_q <= 1'b0;
          bit_q   <= 5'd0;
          if (any_req) begin
            shreg_q <= frame_d;
            we_q    <= sel_we;
            gnt_q   <= sel;
            last_q  <= sel;
          end
        end
        ST_SHIFT: begin
          if (div_done) begin
            div_q   <= '0;
            phase_q <= ~phase_q;
            // Shifting at the end of the high half makes MOSI change on
            // the first cycle of the next low half.
            if (bit_done) begin
              bit_q   <= bit_q + 5'd1;
              shreg_q <= {shreg_q[30:0], 1'b0};
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
          if (sample_en) begin
            rx_q <= {rx_q[6:0], spi_miso};
          end
        end
        ST_HOLD, ST_GAP: begin
          div_q <= div_done ? '0 : div_q + DW'(1);
        end
        default: begin
          div_q <= '0;
        end
      endcase
    end
  end

  // Completion: one-cycle ack on GAP entry; read data lands with it and holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= 8'h00;
      rdata1_q <= 8'h00;
    end else begin
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      if (ack0_d && !we_q) rdata0_q <= rx_q;
      if (ack1_d && !we_q) rdata1_q <= rx_q;
    end
  end

  assign m0_ack   = ack0_q;
  assign m1_ack   = ack1_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;
  assign gnt      = gnt_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Bench for spi_mem_arbiter: two instances (D=1 and D=2), each attached to
// a behavioural SPI RAM. Directed scenarios plus random transactions are
// checked against expectations the bench derives from its own memory image.
module tb_spi_mem_arbiter;

  localparam int NEVER = 100000;

  logic        clk;
  logic        rst_n    [2];
  logic        m0_req   [2];
  logic        m0_we    [2];
  logic [15:0] m0_addr  [2];
  logic [7:0]  m0_wdata [2];
  logic        m0_ack   [2];
  logic [7:0]  m0_rdata [2];
  logic        m1_req   [2];
  logic        m1_we    [2];
  logic [15:0] m1_addr  [2];
  logic [7:0]  m1_wdata [2];
  logic        m1_ack   [2];
  logic [7:0]  m1_rdata [2];
  logic        busy     [2];
  logic        gnt      [2];
  logic        cs_n     [2];
  logic        sck      [2];
  logic        mosi     [2];
  logic        miso     [2];

  // external RAM image and slave observations
  logic [7:0]  mem [2][65536];
  logic [31:0] last_frame [2];
  int          last_bits  [2];
  int          frames     [2];
  int          min_gap    [2];
  int          mosi_viol  [2];
  int          sck_bad    [2];
  logic [7:0]  exp_rd     [2][2];

  int n_cmp = 0;
  int n_err = 0;

  spi_mem_arbiter #(.CLK_DIV(1)) dut_d1 (
    .clk(clk), .rst_n(rst_n[0]),
    .m0_req(m0_req[0]), .m0_we(m0_we[0]), .m0_addr(m0_addr[0]), .m0_wdata(m0_wdata[0]),
    .m0_ack(m0_ack[0]), .m0_rdata(m0_rdata[0]),
    .m1_req(m1_req[0]), .m1_we(m1_we[0]), .m1_addr(m1_addr[0]), .m1_wdata(m1_wdata[0]),
    .m1_ack(m1_ack[0]), .m1_rdata(m1_rdata[0]),
    .busy(busy[0]), .gnt(gnt[0]),
    .spi_cs_n(cs_n[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0])
  );

  spi_mem_arbiter #(.CLK_DIV(2)) dut_d2 (
    .clk(clk), .rst_n(rst_n[1]),
    .m0_req(m0_req[1]), .m0_we(m0_we[1]), .m0_addr(m0_addr[1]), .m0_wdata(m0_wdata[1]),
    .m0_ack(m0_ack[1]), .m0_rdata(m0_rdata[1]),
    .m1_req(m1_req[1]), .m1_we(m1_we[1]), .m1_addr(m1_addr[1]), .m1_wdata(m1_wdata[1]),
    .m1_ack(m1_ack[1]), .m1_rdata(m1_rdata[1]),
    .busy(busy[1]), .gnt(gnt[1]),
    .spi_cs_n(cs_n[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Behavioural 23LC-style RAM, one per instance, sampled 1 time unit after
  // each rising clk edge. Garbage is driven on MISO during cmd/addr and during
  // any SCK-high cycle after the rising one.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slave
    int          bits, gap, hi_cnt, lo_cnt;
    logic [31:0] sh;
    logic [7:0]  cmd, b;
    logic [15:0] addr;
    logic        pcs, psck, pmosi;
    initial begin
      pcs = 1'b1; psck = 1'b0; pmosi = 1'b0;
      bits = 0; gap = 0; hi_cnt = 0; lo_cnt = 0;
      sh = '0; cmd = '0; addr = '0; b = '0;
      miso[gi] = 1'b0;
    end
    always @(posedge clk) begin
      #1;
      if (pcs && !cs_n[gi]) begin
        if (gap < min_gap[gi]) min_gap[gi] = gap;
        bits = 0; sh = '0; hi_cnt = 0; lo_cnt = 1;
        miso[gi] = 1'($urandom_range(0, 1));
      end else if (!cs_n[gi]) begin
        if (pmosi != mosi[gi] && !(psck && !sck[gi])) mosi_viol[gi]++;
        if (!psck && sck[gi]) begin
          if (lo_cnt != gi + 1) sck_bad[gi]++;
          lo_cnt = 0; hi_cnt = 1;
          sh = {sh[30:0], mosi[gi]};
          bits++;
          if (bits == 24) begin
            cmd = sh[23:16]; addr = sh[15:0];
          end
        end else if (psck && !sck[gi]) begin
          if (hi_cnt != gi + 1) sck_bad[gi]++;
          hi_cnt = 0; lo_cnt = 1;
          if (bits >= 24 && bits < 32 && cmd == 8'h03) begin
            b = mem[gi][addr];
            miso[gi] = b[31 - bits];
          end else begin
            miso[gi] = 1'($urandom_range(0, 1));
          end
        end else if (sck[gi]) begin
          hi_cnt++;
          miso[gi] = 1'($urandom_range(0, 1));
        end else begin
          lo_cnt++;
        end
      end
      if (!pcs && cs_n[gi]) begin
        last_frame[gi] = sh;
        last_bits[gi]  = bits;
        frames[gi]++;
        if (bits == 32 && sh[31:24] == 8'h02) mem[gi][sh[23:8]] = sh[7:0];
        gap = 0;
      end
      if (cs_n[gi]) gap++;
      pcs = cs_n[gi]; psck = sck[gi]; pmosi = mosi[gi];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input int p, input logic r, input logic we,
                         input logic [15:0] a, input logic [7:0] d);
    if (p == 0) begin
      m0_req[k] = r; m0_we[k] = we; m0_addr[k] = a; m0_wdata[k] = d;
    end else begin
      m1_req[k] = r; m1_we[k] = we; m1_addr[k] = a; m1_wdata[k] = d;
    end
  endtask

  task automatic check_rdata(input int k, input string tag);
    check({tag, "_rdata0"}, m0_rdata[k], exp_rd[k][0]);
    check({tag, "_rdata1"}, m1_rdata[k], exp_rd[k][1]);
  endtask

  task automatic check_reset(input int k);
    check("rst_cs_n", cs_n[k], 1);
    check("rst_sck", sck[k], 0);
    check("rst_mosi", mosi[k], 0);
    check("rst_busy", busy[k], 0);
    check("rst_gnt", gnt[k], 0);
    check("rst_acks", {m0_ack[k], m1_ack[k]}, 0);
    check("rst_rdata", {m0_rdata[k], m1_rdata[k]}, 0);
  endtask

  task automatic wait_idle(input int k);
    for (int i = 0; i < 2000 && busy[k]; i++) tick();
    check("idle", busy[k], 0);
  endtask

  // One transaction on an otherwise idle instance. Inputs are scrambled and
  // req dropped after drop_at cycles (or at the ack when drop_at is NEVER).
  task automatic txn(input int k, input int p, input logic we, input logic [15:0] a,
                     input logic [7:0] d, input int lat, input int drop_at);
    logic [31:0] exp_frame;
    logic [7:0]  exp_r;
    int          f0, cyc;
    logic        seen;
    exp_frame = {(we ? 8'h02 : 8'h03), a, (we ? d : 8'h00)};
    exp_r     = mem[k][a];
    f0        = frames[k];
    set_req(k, p, 1'b1, we, a, d);
    tick();
    check("t1_cs_n", cs_n[k], 0);
    check("t1_busy", busy[k], 1);
    check("t1_sck", sck[k], 0);
    check("t1_mosi", mosi[k], exp_frame[31]);
    check("t1_gnt", gnt[k], p);
    cyc = 1; seen = 1'b0;
    while (!seen && cyc < 2000) begin
      if (cyc == drop_at)
        set_req(k, p, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
      tick();
      cyc++;
      if (m0_ack[k] || m1_ack[k]) seen = 1'b1;
    end
    check("ack_seen", seen, 1);
    check("ack_own", (p != 0) ? m1_ack[k] : m0_ack[k], 1);
    check("ack_other", (p != 0) ? m0_ack[k] : m1_ack[k], 0);
    check("latency", cyc, lat);
    check("ack_cs_n", cs_n[k], 1);
    check("ack_gnt", gnt[k], p);
    if (!we) exp_rd[k][p] = exp_r;
    check_rdata(k, "ack");
    set_req(k, p, 1'b0, 1'b0, 16'h0, 8'h0);
    tick();
    check("ack_width", (p != 0) ? m1_ack[k] : m0_ack[k], 0);
    wait_idle(k);
    repeat (3) tick();
    check("frame_count", frames[k] - f0, 1);
    check("frame", last_frame[k], exp_frame);
    check("frame_bits", last_bits[k], 32);
    check("mosi_timing", mosi_viol[k], 0);
    check("sck_phases", sck_bad[k], 0);
    $display("txn inst=%0d port=%0d we=%0d addr=%h wdata=%h lat=%0d rdata=%h",
             k, p, we, a, d, cyc, (p != 0) ? m1_rdata[k] : m0_rdata[k]);
  endtask

  initial begin
    int          port, cyc, f0, acks;
    logic        seen;
    logic [15:0] a0, a1;

    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      set_req(k, 0, 1'b0, 1'b0, 16'h0, 8'h0);
      set_req(k, 1, 1'b0, 1'b0, 16'h0, 8'h0);
      frames[k] = 0; mosi_viol[k] = 0; sck_bad[k] = 0; min_gap[k] = 1000;
      last_frame[k] = '0; last_bits[k] = 0;
      exp_rd[k][0] = 8'h00; exp_rd[k][1] = 8'h00;
      for (int a = 0; a < 65536; a++) mem[k][a] = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    tick();
    check_reset(0);

    // single read, D=1
    mem[0][16'h1234] = 8'hA5;
    txn(0, 0, 1'b0, 16'h1234, 8'h00, 66, NEVER);
    check("read_a5", m0_rdata[0], 8'hA5);

    // single write, D=2
    txn(1, 1, 1'b1, 16'hBEEF, 8'h5A, 131, NEVER);
    check("write_mem", mem[1][16'hBEEF], 8'h5A);

    // MISO sampling: data byte 3C under garbage, at both dividers
    mem[1][16'h0F0F] = 8'h3C;
    txn(1, 0, 1'b0, 16'h0F0F, 8'h00, 131, NEVER);
    check("miso_d2", m0_rdata[1], 8'h3C);
    mem[0][16'hA55A] = 8'h3C;
    txn(0, 1, 1'b0, 16'hA55A, 8'h00, 66, NEVER);
    check("miso_d1", m1_rdata[0], 8'h3C);

    // contention from reset: grants alternate 0,1,0,1
    @(negedge clk) rst_n[0] = 1'b0;
    @(negedge clk) rst_n[0] = 1'b1;
    exp_rd[0][0] = 8'h00; exp_rd[0][1] = 8'h00;
    tick();
    a0 = 16'($urandom); a1 = a0 ^ 16'h8001;
    f0 = frames[0];
    min_gap[0] = 1000;
    set_req(0, 0, 1'b1, 1'b0, a0, 8'h00);
    set_req(0, 1, 1'b1, 1'b0, a1, 8'h00);
    cyc = 0;
    for (int n = 0; n < 4; n++) begin
      seen = 1'b0;
      while (!seen && cyc < 500) begin
        tick(); cyc++;
        if (m0_ack[0] || m1_ack[0]) seen = 1'b1;
      end
      check("cont_seen", seen, 1);
      port = m1_ack[0] ? 1 : 0;
      check("cont_order", port, n % 2);
      check("cont_single", m0_ack[0] & m1_ack[0], 0);
      check("cont_lat", cyc, (n == 0) ? 66 : 67);
      check("cont_gnt", gnt[0], n % 2);
      exp_rd[0][port] = mem[0][(port != 0) ? a1 : a0];
      check_rdata(0, "cont");
      $display("contention ack %0d port=%0d cycles=%0d", n, port, cyc);
      if (n == 3) begin
        set_req(0, 0, 1'b0, 1'b0, 16'h0, 8'h0);
        set_req(0, 1, 1'b0, 1'b0, 16'h0, 8'h0);
      end
      tick();
      check("cont_width", m0_ack[0] | m1_ack[0], 0);
      cyc = 1;
    end
    wait_idle(0);
    repeat (3) tick();
    check("cont_frames", frames[0] - f0, 4);
    check("cont_gap", min_gap[0], 2);

    // request withdrawn after 10 cycles, inputs scrambled
    f0 = frames[0];
    txn(0, 0, 1'b0, 16'h0777, 8'h00, 66, 10);
    repeat (150) tick();
    check("withdraw_no_retrigger", frames[0] - f0, 1);
    check("withdraw_idle", busy[0], 0);

    // reset during bit 20
    mem[0][16'h4242] = 8'h11;
    set_req(0, 0, 1'b1, 1'b1, 16'h4242, 8'hEE);
    repeat (41) tick();
    check("pre_rst_cs", cs_n[0], 0);
    #3 rst_n[0] = 1'b0;
    #1;
    check_reset(0);
    set_req(0, 0, 1'b0, 1'b0, 16'h0, 8'h0);
    exp_rd[0][0] = 8'h00; exp_rd[0][1] = 8'h00;
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    acks = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (m0_ack[0] || m1_ack[0]) acks++;
    end
    check("rst_no_ack", acks, 0);
    check("rst_partial_bits", last_bits[0], 20);
    check("rst_no_write", mem[0][16'h4242], 8'h11);
    txn(0, 1, 1'b0, 16'h2468, 8'h00, 66, NEVER);
    set_req(0, 0, 1'b1, 1'b0, 16'h1357, 8'h00);
    set_req(0, 1, 1'b1, 1'b0, 16'h9BDF, 8'h00);
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 500) begin
      tick(); cyc++;
      if (m0_ack[0] || m1_ack[0]) seen = 1'b1;
    end
    check("tie_seen", seen, 1);
    check("tie_port0", m0_ack[0], 1);
    exp_rd[0][0] = mem[0][16'h1357];
    set_req(0, 0, 1'b0, 1'b0, 16'h0, 8'h0);
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 500) begin
      tick(); cyc++;
      if (m0_ack[0] || m1_ack[0]) seen = 1'b1;
    end
    check("tie_second", m1_ack[0], 1);
    exp_rd[0][1] = mem[0][16'h9BDF];
    set_req(0, 1, 1'b0, 1'b0, 16'h0, 8'h0);
    check_rdata(0, "tie");
    wait_idle(0);
    tick();

    // random traffic over a small address window so reads see earlier writes
    for (int i = 0; i < 16; i++) begin
      int          k, p;
      logic        we;
      logic [15:0] a;
      k  = int'($urandom_range(0, 1));
      p  = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = 16'($urandom_range(0, 7));
      txn(k, p, we, a, 8'($urandom), (k != 0) ? 131 : 66, NEVER);
      check_rdata(k, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
